// File: rtl/watch_set_ctrl_pkg.sv
// Shared types and constants for the watch time-set controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package watch_set_ctrl_pkg;

  // Edit mode. The encoding is visible on the bench hierarchy, so keep it fixed.
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } state_t;

  // Field-blank select driven to the display block.
  localparam logic [1:0] BLANK_NONE = 2'b00;
  localparam logic [1:0] BLANK_SEC  = 2'b01;
  localparam logic [1:0] BLANK_MIN  = 2'b10;
  localparam logic [1:0] BLANK_HOUR = 2'b11;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

endpackage

// File: rtl/watch_set_ctrl_mod_counter.sv
// Wrap-around 7-bit counter 0..MAX with a same-cycle carry on wrap.
// Latency: value updates on the edge where inc is sampled; carry is combinational.
// Backpressure: none; every inc pulse is taken.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset (clears value)
//   inc        : advance by one this cycle
//   value      : current count, 0..MAX
//   carry      : inc while value==MAX, i.e. the count wraps on this edge
module mod_counter #(
  parameter int MAX = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [6:0] value,
  output logic       carry
);

  logic at_max;

  assign at_max = (value == 7'(MAX));
  assign carry  = inc & at_max;

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= 7'd0;
    end else if (inc) begin
      value <= at_max ? 7'd0 : value + 7'd1;
    end
  end

endmodule

// File: rtl/watch_set_ctrl.sv
// Timekeeping plus time-set controller: HMS counters, edit-mode FSM, blink of edited field.
// Latency: time fields update on the edge the tick/inc is sampled; blank_sel/set_mode decode state combinationally.
// Backpressure: none; one-cycle pulses are consumed or dropped the cycle they arrive.
//
// Ports:
//   clk, reset       : single clock, synchronous active-high reset
//   tick_1hz         : 1 Hz one-cycle pulse from the prescaler
//   btn_mode/btn_inc : debounced, edge-detected one-cycle button pulses
//   sec/min/hour     : current time (display num0/num1/num2)
//   blank_sel        : field to blank (display enable), 00 none/01 sec/10 min/11 hour
//   set_mode         : high in any SET state
module watch_set_ctrl
  import watch_set_ctrl_pkg::*;
#(
  parameter int BLINK_HALF = 25000000,
  parameter int HOUR_MAX   = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [6:0] sec,
  output logic [6:0] min,
  output logic [6:0] hour,
  output logic [1:0] blank_sel,
  output logic       set_mode
);

  localparam int              CW        = $clog2(BLINK_HALF);
  localparam logic [CW-1:0]   BLINK_TC  = CW'(BLINK_HALF - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   blink_cnt, blink_cnt_nxt;
  logic            blink_phase, blink_phase_nxt;

  logic            inc_ok;
  logic            sec_inc, min_inc, hour_inc;
  logic            sec_carry, min_carry;

  // btn_mode wins over btn_inc; inc only means something while editing.
  assign inc_ok = btn_inc & ~btn_mode & (state != RUN);

  // In RUN the tick ripples through the carries in one cycle; in SET the
  // selected field alone advances, and its carry is masked so nothing ripples.
  assign sec_inc  = (state == RUN) ? tick_1hz  : (inc_ok & (state == SET_SEC));
  assign min_inc  = (state == RUN) ? sec_carry : (inc_ok & (state == SET_MIN));
  assign hour_inc = (state == RUN) ? min_carry : (inc_ok & (state == SET_HOUR));

  mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .reset (reset),
    .inc   (sec_inc),
    .value (sec),
    .carry (sec_carry)
  );

  mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .reset (reset),
    .inc   (min_inc),
    .value (min),
    .carry (min_carry)
  );

  // Day rollover has no consumer, so the hour carry is left open.
  mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk   (clk),
    .reset (reset),
    .inc   (hour_inc),
    .value (hour),
    .carry ()
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      state       <= state_nxt;
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    blink_cnt_nxt   = blink_cnt;
    blink_phase_nxt = blink_phase;

    if (btn_mode) begin
      case (state)
        RUN:      state_nxt = SET_HOUR;
        SET_HOUR: state_nxt = SET_MIN;
        SET_MIN:  state_nxt = SET_SEC;
        SET_SEC:  state_nxt = RUN;
        default:  state_nxt = RUN;
      endcase
    end

    // Restart the blink with the field visible after any press, and park it in RUN.
    if (state_nxt == RUN || btn_mode || inc_ok) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = 1'b0;
    end else if (blink_cnt == BLINK_TC) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = ~blink_phase;
    end else begin
      blink_cnt_nxt   = blink_cnt + 1'b1;
    end
  end

  always_comb begin
    blank_sel = BLANK_NONE;
    if (blink_phase) begin
      case (state)
        SET_SEC:  blank_sel = BLANK_SEC;
        SET_MIN:  blank_sel = BLANK_MIN;
        SET_HOUR: blank_sel = BLANK_HOUR;
        default:  blank_sel = BLANK_NONE;
      endcase
    end
  end

  assign set_mode = (state != RUN);

endmodule

// File: tb/tb_watch_set_ctrl.sv
module tb_watch_set_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;

  logic [6:0] sec, min, hour;
  logic [1:0] blank_sel;
  logic       set_mode;
  logic [6:0] sec_b, min_b, hour_b;
  logic [1:0] blank_sel_b;
  logic       set_mode_b;

  always #5 clk = ~clk;

  watch_set_ctrl #(.BLINK_HALF(4), .HOUR_MAX(23)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec(sec), .min(min), .hour(hour), .blank_sel(blank_sel), .set_mode(set_mode)
  );

  // Twelve-hour variant fed the same stimulus; only its hour differs.
  watch_set_ctrl #(.BLINK_HALF(4), .HOUR_MAX(11)) dut_b (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec(sec_b), .min(min_b), .hour(hour_b), .blank_sel(blank_sel_b), .set_mode(set_mode_b)
  );

  typedef struct {
    int         cyc;
    logic [6:0] s, m, h, hb;
    logic [1:0] bl;
    logic       sm;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc_cnt) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", e.name, e.cyc, cyc_cnt);
      end else if (sec !== e.s || min !== e.m || hour !== e.h || blank_sel !== e.bl || set_mode !== e.sm ||
                   sec_b !== e.s || min_b !== e.m || hour_b !== e.hb || blank_sel_b !== e.bl || set_mode_b !== e.sm) begin
        errors++;
        $display("FAIL %s: got %0d:%0d:%0d bl=%b sm=%b | b %0d:%0d:%0d bl=%b sm=%b ; want %0d:%0d:%0d bl=%b sm=%b | b hour %0d",
                 e.name, hour, min, sec, blank_sel, set_mode, hour_b, min_b, sec_b, blank_sel_b, set_mode_b,
                 e.h, e.m, e.s, e.bl, e.sm, e.hb);
      end
    end
  end

  // One clock of stimulus: pulses are held across exactly one active edge.
  task automatic step(input logic t, input logic md, input logic in);
    tick_1hz = t;
    btn_mode = md;
    btn_inc  = in;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic expect_out(input int s, input int m, input int h, input int hb,
                            input logic [1:0] bl, input logic sm, input string name);
    exp_t x;
    x.cyc = cyc_cnt; x.s = 7'(s); x.m = 7'(m); x.h = 7'(h); x.hb = 7'(hb);
    x.bl = bl; x.sm = sm; x.name = name;
    q.push_back(x);
  endtask

  logic [1:0] blink_tbl [8] = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};

  initial begin
    #2;
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    expect_out(0, 0, 0, 0, 2'b00, 1'b0, "reset");

    step(1'b1, 1'b0, 1'b0); expect_out(1, 0, 0, 0, 2'b00, 1'b0, "tick1");
    step(1'b1, 1'b0, 1'b0); expect_out(2, 0, 0, 0, 2'b00, 1'b0, "tick2");
    step(1'b1, 1'b0, 1'b0); expect_out(3, 0, 0, 0, 2'b00, 1'b0, "tick3");

    // Enter SET_HOUR; ticks are applied but must be ignored.
    step(1'b0, 1'b1, 1'b0); expect_out(3, 0, 0, 0, 2'b00, 1'b1, "enter_set_hour");
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0);
      expect_out(3, 0, 0, 0, blink_tbl[i], 1'b1, "blink_hour");
    end
    idles(4); expect_out(3, 0, 0, 0, 2'b11, 1'b1, "blink_hour_phase1");
    step(1'b0, 1'b0, 1'b1); expect_out(3, 0, 1, 1, 2'b00, 1'b1, "inc_hour_restart");
    step(1'b0, 1'b0, 1'b1); expect_out(3, 0, 2, 2, 2'b00, 1'b1, "inc_hour2");
    idles(3); expect_out(3, 0, 2, 2, 2'b00, 1'b1, "blink_after_inc_lo");
    idles(1); expect_out(3, 0, 2, 2, 2'b11, 1'b1, "blink_after_inc_hi");

    incs(21); expect_out(3, 0, 23, 11, 2'b00, 1'b1, "hour_preload");
    step(1'b0, 1'b1, 1'b1); expect_out(3, 0, 23, 11, 2'b00, 1'b1, "mode_beats_inc");

    // SET_MIN: wrap without carry into hour.
    incs(58); expect_out(3, 58, 23, 11, 2'b00, 1'b1, "min_58");
    incs(3);  expect_out(3, 1, 23, 11, 2'b00, 1'b1, "min_wrap");
    incs(58); idles(4); expect_out(3, 59, 23, 11, 2'b10, 1'b1, "min_59_blink");

    // SET_SEC: wrap without carry into min.
    step(1'b0, 1'b1, 1'b0); expect_out(3, 59, 23, 11, 2'b00, 1'b1, "enter_set_sec");
    incs(56); expect_out(59, 59, 23, 11, 2'b00, 1'b1, "sec_59");
    incs(1);  expect_out(0, 59, 23, 11, 2'b00, 1'b1, "sec_wrap");
    incs(59); idles(4); expect_out(59, 59, 23, 11, 2'b01, 1'b1, "sec_59_blink");

    // Mode+tick in SET_SEC: tick dropped, back to RUN.
    step(1'b1, 1'b1, 1'b0); expect_out(59, 59, 23, 11, 2'b00, 1'b0, "back_to_run");
    step(1'b1, 1'b0, 1'b0); expect_out(0, 0, 0, 0, 2'b00, 1'b0, "full_rollover");
    step(1'b0, 1'b0, 1'b1); expect_out(0, 0, 0, 0, 2'b00, 1'b0, "inc_ignored_run");

    idles(5); expect_out(5, 0, 0, 0, 2'b00, 1'b0, "sec_5");
    step(1'b1, 1'b1, 1'b0); expect_out(6, 0, 0, 0, 2'b00, 1'b1, "mode_and_tick_run");

    // Build 10:20:30 and park in SET_MIN, then reset.
    incs(10);
    step(1'b0, 1'b1, 1'b0); incs(20);
    step(1'b0, 1'b1, 1'b0); incs(24);
    step(1'b0, 1'b1, 1'b0); expect_out(30, 20, 10, 10, 2'b00, 1'b0, "time_10_20_30");
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    idles(4); expect_out(30, 20, 10, 10, 2'b10, 1'b1, "set_min_blank");
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    expect_out(0, 0, 0, 0, 2'b00, 1'b0, "reset_mid_edit");
    step(1'b1, 1'b0, 1'b0); expect_out(1, 0, 0, 0, 2'b00, 1'b0, "tick_after_reset");

    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
